// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   OP_ADD / OP_SUB : encoding of the in_sub operation select
//   cfg_legal()     : parameter legality check used at elaboration
package pipelined_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic logic cfg_legal(input int n, input int stages);
        return (n >= 2) && (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_addsub_rca_chunk.sv
// rca_chunk: W-bit ripple-carry adder slice.
//   a, b      : chunk operands (b already inverted for subtract)
//   cin       : carry into bit 0
//   sum       : chunk sum
//   cout      : carry out of bit W-1
//   c_msb_in  : carry into bit W-1 (used for overflow on the top chunk)
module rca_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic carry;

    // Full-adder chain written as a loop over a running carry variable.
    always_comb begin
        sum      = '0;
        carry    = cin;
        c_msb_in = cin;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                c_msb_in = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: N-bit add/subtract split into STAGES registered
// ripple-carry chunks with a valid/ready handshake on both sides.
//   clk, rst                    : clock, async active-high reset
//   in_valid/in_ready           : operand beat handshake
//   in_a, in_b, in_cin, in_sub  : operands, carry/borrow in, op select
//   out_valid/out_ready         : result beat handshake
//   out_sum, out_carry          : result and carry out (sub: 1 = no borrow)
//   out_ovf, out_zero           : signed overflow, result-is-zero
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_carry,
    output logic         out_ovf,
    output logic         out_zero
);

    localparam int W    = N / STAGES;
    localparam int LAST = STAGES - 1;

    if (!cfg_legal(N, STAGES)) begin : g_bad_cfg
        $error("pipelined_addsub: need N >= 2, 1 <= STAGES <= N and N %% STAGES == 0");
    end

    // Subtract is a + ~b + ~cin; inversion happens once, here.
    logic [N-1:0] b_eff;
    logic         cin_eff;

    assign b_eff   = (in_sub == OP_ADD) ? in_b : ~in_b;
    assign cin_eff = (in_sub == OP_SUB) ? ~in_cin : in_cin;

    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_adv;

    // A stage stalls only when it and every stage after it hold a beat and
    // the consumer is not taking one; written without a feedback chain.
    always_comb begin
        logic all_full;
        all_full  = !out_ready;
        stage_adv = '0;
        for (int k = LAST; k >= 0; k--) begin
            all_full     = all_full & stage_valid[k];
            stage_adv[k] = !all_full;
        end
    end

    assign in_ready = stage_adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW = (k + 1) * W;   // finished sum bits held here
        localparam int RW = N - SW;        // operand bits still to be added

        logic [W-1:0]  a_chunk;
        logic [W-1:0]  b_chunk;
        logic [W-1:0]  chunk_sum;
        logic          c_in;
        logic          v_in;
        logic          chunk_cout;
        logic          chunk_cmsb;
        logic [SW-1:0] sum_d;

        logic          v_q;
        logic [SW-1:0] sum_q;
        logic          carry_q;

        if (k == 0) begin : g_src
            assign a_chunk = in_a[W-1:0];
            assign b_chunk = b_eff[W-1:0];
            assign c_in    = cin_eff;
            assign v_in    = in_valid;
            assign sum_d   = chunk_sum;
        end else begin : g_src
            assign a_chunk = g_stage[k-1].g_rem.a_rem_q[W-1:0];
            assign b_chunk = g_stage[k-1].g_rem.b_rem_q[W-1:0];
            assign c_in    = g_stage[k-1].carry_q;
            assign v_in    = g_stage[k-1].v_q;
            assign sum_d   = {chunk_sum, g_stage[k-1].sum_q};
        end

        rca_chunk #(.W(W)) u_rca (
            .a        (a_chunk),
            .b        (b_chunk),
            .cin      (c_in),
            .sum      (chunk_sum),
            .cout     (chunk_cout),
            .c_msb_in (chunk_cmsb)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q     <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (stage_adv[k]) begin
                v_q     <= v_in;
                sum_q   <= sum_d;
                carry_q <= chunk_cout;
            end
        end

        assign stage_valid[k] = v_q;

        // Operand chunks not yet consumed ride along, already inverted.
        if (k < LAST) begin : g_rem
            logic [RW-1:0] a_rem_d;
            logic [RW-1:0] b_rem_d;
            logic [RW-1:0] a_rem_q;
            logic [RW-1:0] b_rem_q;

            if (k == 0) begin : g_rem_src
                assign a_rem_d = in_a[N-1:W];
                assign b_rem_d = b_eff[N-1:W];
            end else begin : g_rem_src
                assign a_rem_d = g_stage[k-1].g_rem.a_rem_q[RW+W-1:W];
                assign b_rem_d = g_stage[k-1].g_rem.b_rem_q[RW+W-1:W];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (stage_adv[k]) begin
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                end
            end
        end

        if (k == LAST) begin : g_out
            logic cmsb_q;
            logic zero_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cmsb_q <= 1'b0;
                    zero_q <= 1'b0;
                end else if (stage_adv[k]) begin
                    cmsb_q <= chunk_cmsb;
                    zero_q <= (sum_d == '0);
                end
            end

            assign out_valid = v_q;
            assign out_sum   = sum_q;
            assign out_carry = carry_q;
            assign out_ovf   = cmsb_q ^ carry_q;
            assign out_zero  = zero_q;
        end else begin : g_mid
            // Carry into the chunk MSB only matters on the top chunk.
            logic unused_cmsb;
            assign unused_cmsb = chunk_cmsb;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;
    import pipelined_addsub_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // N=8, STAGES=2
    logic       m_in_valid = 1'b0, m_in_ready, m_in_cin = 1'b0, m_in_sub = 1'b0;
    logic       m_out_valid, m_out_ready = 1'b1, m_out_carry, m_out_ovf, m_out_zero;
    logic [7:0] m_in_a = '0, m_in_b = '0, m_out_sum;

    // N=16, STAGES=4
    logic        w_in_valid = 1'b0, w_in_ready, w_in_cin = 1'b0, w_in_sub = 1'b0;
    logic        w_out_valid, w_out_ready = 1'b1, w_out_carry, w_out_ovf, w_out_zero;
    logic [15:0] w_in_a = '0, w_in_b = '0, w_out_sum;

    // N=8, STAGES=1
    logic       s_in_valid = 1'b0, s_in_ready, s_in_cin = 1'b0, s_in_sub = 1'b0;
    logic       s_out_valid, s_out_ready = 1'b1, s_out_carry, s_out_ovf, s_out_zero;
    logic [7:0] s_in_a = '0, s_in_b = '0, s_out_sum;

    pipelined_addsub #(.N(8), .STAGES(2)) dut_m (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_a(m_in_a), .in_b(m_in_b), .in_cin(m_in_cin), .in_sub(m_in_sub),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_sum(m_out_sum), .out_carry(m_out_carry), .out_ovf(m_out_ovf), .out_zero(m_out_zero)
    );

    pipelined_addsub #(.N(16), .STAGES(4)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_cin(w_in_cin), .in_sub(w_in_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_sum(w_out_sum), .out_carry(w_out_carry), .out_ovf(w_out_ovf), .out_zero(w_out_zero)
    );

    pipelined_addsub #(.N(8), .STAGES(1)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin), .in_sub(s_in_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_carry(s_out_carry), .out_ovf(s_out_ovf), .out_zero(s_out_zero)
    );

    // Drive one beat into the 8/2 instance on an idle pipeline and wait for it.
    task automatic issue_main(input logic [7:0] a, input logic [7:0] b, input logic cin,
                              input logic sub, output logic [7:0] sum, output logic carry,
                              output logic ovf, output logic zero, output int lat);
        @(negedge clk);
        m_in_a = a; m_in_b = b; m_in_cin = cin; m_in_sub = sub;
        m_in_valid = 1'b1; m_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_in_valid = 1'b0;
        lat = 1;
        while (!m_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        sum = m_out_sum; carry = m_out_carry; ovf = m_out_ovf; zero = m_out_zero;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", m_out_valid); end
        n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", m_in_ready); end
        n_cmp++; if (m_out_sum !== 8'h00) begin n_err++; $display("FAIL reset_out_sum: got %h want 00", m_out_sum); end
        n_cmp++; if ({m_out_carry, m_out_ovf, m_out_zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {m_out_carry, m_out_ovf, m_out_zero}); end
        n_cmp++; if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_wide_hs: got valid=%b ready=%b want 0/1", w_out_valid, w_in_ready); end
        n_cmp++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_single_hs: got valid=%b ready=%b want 0/1", s_out_valid, s_in_ready); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        logic [7:0] ta [8], tb [8], ts [8];
        logic       tc [8], tsub [8], ec [8], eo [8], ez [8];
        logic [7:0] sum;
        logic       carry, ovf, zero;
        int         lat;
        ta   = '{8'hFF, 8'h05, 8'h80, 8'h7F, 8'h10, 8'h03, 8'h00, 8'h0F};
        tb   = '{8'h01, 8'h07, 8'h01, 8'h01, 8'h20, 8'h03, 8'h00, 8'h01};
        tc   = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        tsub = '{OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_ADD};
        ts   = '{8'h00, 8'hFE, 8'h7F, 8'h80, 8'h31, 8'hFF, 8'h00, 8'h10};
        ec   = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
        eo   = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        ez   = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
        for (int i = 0; i < 8; i++) begin
            issue_main(ta[i], tb[i], tc[i], tsub[i], sum, carry, ovf, zero, lat);
            n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL vec%0d_latency: got %0d want 2", i, lat); end
            n_cmp++; if (sum !== ts[i]) begin n_err++; $display("FAIL vec%0d_sum: got %h want %h", i, sum, ts[i]); end
            n_cmp++; if (carry !== ec[i]) begin n_err++; $display("FAIL vec%0d_carry: got %b want %b", i, carry, ec[i]); end
            n_cmp++; if (ovf !== eo[i]) begin n_err++; $display("FAIL vec%0d_ovf: got %b want %b", i, ovf, eo[i]); end
            n_cmp++; if (zero !== ez[i]) begin n_err++; $display("FAIL vec%0d_zero: got %b want %b", i, zero, ez[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea [6], eb [6], es [6];
        logic       ecin [6], esub [6], ec [6], eo [6];
        logic       pat [12];
        logic [7:0] hold_sum;
        logic       hold_c, hold_o, hold_z, exp_rdy, stalled_prev;
        int         acc, emi, held, cyc, low_seen;
        ea   = '{8'h01, 8'h10, 8'h50, 8'hF0, 8'h00, 8'h40};
        eb   = '{8'h02, 8'h20, 8'h10, 8'h20, 8'h01, 8'h40};
        ecin = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        esub = '{OP_ADD, OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_ADD};
        es   = '{8'h03, 8'h31, 8'h40, 8'h10, 8'hFF, 8'h80};
        ec   = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        eo   = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        acc = 0; emi = 0; cyc = 0; low_seen = 0; stalled_prev = 1'b0;
        hold_sum = '0; hold_c = 1'b0; hold_o = 1'b0; hold_z = 1'b0;
        while (emi < 6 && cyc < 40) begin
            @(negedge clk);
            m_out_ready = (cyc < 12) ? pat[cyc] : 1'b1;
            if (acc < 6) begin
                m_in_valid = 1'b1; m_in_a = ea[acc]; m_in_b = eb[acc];
                m_in_cin = ecin[acc]; m_in_sub = esub[acc];
            end else begin
                m_in_valid = 1'b0;
            end
            #1;
            held = acc - emi;
            exp_rdy = (held == 2 && !m_out_ready) ? 1'b0 : 1'b1;
            n_cmp++; if (m_in_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, m_in_ready, exp_rdy); end
            if (!m_in_ready) low_seen++;
            if (stalled_prev) begin
                n_cmp++;
                if (m_out_valid !== 1'b1 || m_out_sum !== hold_sum || m_out_carry !== hold_c ||
                    m_out_ovf !== hold_o || m_out_zero !== hold_z) begin
                    n_err++;
                    $display("FAIL b2b_hold cyc%0d: got v=%b sum=%h c=%b o=%b z=%b want v=1 sum=%h c=%b o=%b z=%b",
                             cyc, m_out_valid, m_out_sum, m_out_carry, m_out_ovf, m_out_zero, hold_sum, hold_c, hold_o, hold_z);
                end
            end
            if (m_out_valid && m_out_ready) begin
                n_cmp++;
                if (m_out_sum !== es[emi] || m_out_carry !== ec[emi] || m_out_ovf !== eo[emi]) begin
                    n_err++;
                    $display("FAIL b2b_beat%0d: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                             emi, m_out_sum, m_out_carry, m_out_ovf, es[emi], ec[emi], eo[emi]);
                end
                emi++;
            end
            stalled_prev = m_out_valid && !m_out_ready;
            hold_sum = m_out_sum; hold_c = m_out_carry; hold_o = m_out_ovf; hold_z = m_out_zero;
            if (m_in_valid && m_in_ready) acc++;
            cyc++;
        end
        @(negedge clk);
        m_in_valid = 1'b0; m_out_ready = 1'b1;
        #1;
        n_cmp++; if (emi !== 6) begin n_err++; $display("FAIL b2b_emitted: got %0d want 6", emi); end
        n_cmp++; if (acc !== 6) begin n_err++; $display("FAIL b2b_accepted: got %0d want 6", acc); end
        n_cmp++; if ((low_seen > 0) !== 1'b1) begin n_err++; $display("FAIL b2b_backpressure_seen: got %0d want >0", low_seen); end
        n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_no_extra_beat: got %b want 0", m_out_valid); end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] sum;
        logic       carry, ovf, zero;
        int         lat;
        @(negedge clk);
        m_out_ready = 1'b0;
        m_in_valid = 1'b1; m_in_a = 8'h11; m_in_b = 8'h22; m_in_cin = 1'b0; m_in_sub = OP_ADD;
        @(posedge clk);
        @(negedge clk);
        m_in_a = 8'h33; m_in_b = 8'h44;
        @(posedge clk);
        @(negedge clk);
        m_in_valid = 1'b0;
        #1;
        n_cmp++; if (m_in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full_in_ready: got %b want 0", m_in_ready); end
        n_cmp++; if (m_out_valid !== 1'b1 || m_out_sum !== 8'h33) begin n_err++; $display("FAIL mid_full_out: got v=%b sum=%h want v=1 sum=33", m_out_valid, m_out_sum); end
        rst = 1'b1;
        #1;
        n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid: got %b want 0", m_out_valid); end
        n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", m_in_ready); end
        n_cmp++; if (m_out_sum !== 8'h00 || m_out_carry !== 1'b0) begin n_err++; $display("FAIL mid_rst_data: got sum=%h c=%b want 00/0", m_out_sum, m_out_carry); end
        @(negedge clk);
        rst = 1'b0;
        m_out_ready = 1'b1;
        issue_main(8'h2A, 8'h15, 1'b0, OP_ADD, sum, carry, ovf, zero, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL post_rst_latency: got %0d want 2", lat); end
        n_cmp++; if (sum !== 8'h3F || carry !== 1'b0) begin n_err++; $display("FAIL post_rst_result: got sum=%h c=%b want 3F/0", sum, carry); end
        @(negedge clk);
        #1;
        n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_discarded: got %b want 0", m_out_valid); end
    endtask

    task automatic test_wide();
        logic [15:0] wa [5], wb [5], ws [5];
        logic        wsub [5], wc [5];
        int          lat, got;
        @(negedge clk);
        w_in_valid = 1'b1; w_in_a = 16'hFFFF; w_in_b = 16'h0001; w_in_cin = 1'b0; w_in_sub = OP_ADD;
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        lat = 1;
        while (!w_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL wide_latency: got %0d want 4", lat); end
        n_cmp++; if (w_out_sum !== 16'h0000 || w_out_carry !== 1'b1 || w_out_zero !== 1'b1) begin
            n_err++; $display("FAIL wide_ffff_plus_1: got sum=%h c=%b z=%b want 0000/1/1", w_out_sum, w_out_carry, w_out_zero);
        end
        wa   = '{16'h00FF, 16'h0FFF, 16'h1000, 16'h7FFF, 16'h1234};
        wb   = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h4321};
        wsub = '{OP_ADD, OP_ADD, OP_SUB, OP_ADD, OP_ADD};
        ws   = '{16'h0100, 16'h1000, 16'h0FFF, 16'h8000, 16'h5555};
        wc   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        got = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c < 5) begin
                w_in_valid = 1'b1; w_in_a = wa[c]; w_in_b = wb[c]; w_in_sub = wsub[c];
            end else begin
                w_in_valid = 1'b0;
            end
            #1;
            if (c < 5) begin
                n_cmp++; if (w_in_ready !== 1'b1) begin n_err++; $display("FAIL wide_stream_ready cyc%0d: got %b want 1", c, w_in_ready); end
            end
            if (w_out_valid) begin
                n_cmp++;
                if (got >= 5 || c !== got + 4 || w_out_sum !== ws[got % 5] || w_out_carry !== wc[got % 5]) begin
                    n_err++;
                    $display("FAIL wide_stream_beat%0d: got cyc=%0d sum=%h c=%b want cyc=%0d sum=%h c=%b",
                             got, c, w_out_sum, w_out_carry, got + 4, ws[got % 5], wc[got % 5]);
                end
                got++;
            end
        end
        n_cmp++; if (got !== 5) begin n_err++; $display("FAIL wide_stream_count: got %0d want 5", got); end
    endtask

    task automatic test_single_stage();
        int lat;
        @(negedge clk);
        s_in_valid = 1'b1; s_in_a = 8'hC8; s_in_b = 8'h38; s_in_cin = 1'b0; s_in_sub = OP_ADD;
        @(posedge clk);
        @(negedge clk);
        s_in_a = 8'h20; s_in_b = 8'h01; s_in_cin = 1'b1; s_in_sub = OP_SUB;
        lat = 1;
        #1;
        n_cmp++; if (s_out_valid !== 1'b1) begin n_err++; $display("FAIL single_latency: got valid=%b want 1 after %0d cycle", s_out_valid, lat); end
        n_cmp++; if (s_out_sum !== 8'h00 || s_out_carry !== 1'b1 || s_out_zero !== 1'b1) begin
            n_err++; $display("FAIL single_add: got sum=%h c=%b z=%b want 00/1/1", s_out_sum, s_out_carry, s_out_zero);
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        #1;
        n_cmp++; if (s_out_valid !== 1'b1 || s_out_sum !== 8'h1E || s_out_carry !== 1'b1 || s_out_zero !== 1'b0) begin
            n_err++; $display("FAIL single_sub: got v=%b sum=%h c=%b z=%b want 1/1E/1/0", s_out_valid, s_out_sum, s_out_carry, s_out_zero);
        end
        @(negedge clk);
        #1;
        n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", s_out_valid); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_reset_midstream();
        test_wide();
        test_single_stage();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
